// File: rtl/dds_pkg.sv
// Shared types and helpers for the two-channel DDS sample feeder.
package dds_pkg;

  localparam int unsigned Q_W      = 8;
  localparam logic [11:0] MIDSCALE = 12'd2048;
  // pi scaled by 2**30
  localparam longint      PI_S     = 64'sd3373259426;

  typedef enum logic [1:0] {IDLE, FETCH, CALC, WAIT_RDY} fsm_t;

  typedef struct packed {
    logic           neg;
    logic [Q_W-1:0] idx;
  } qmap_t;

  // Top Q_W+2 phase bits -> sign of the half-wave and mirrored quarter-wave index.
  function automatic qmap_t quad_map(input logic [Q_W+1:0] ptop);
    qmap_t r;
    r.neg = ptop[Q_W+1];
    r.idx = ptop[Q_W] ? ~ptop[Q_W-1:0] : ptop[Q_W-1:0];
    return r;
  endfunction

  // round(2047*sin((i+0.5)*pi/2/2**Q_W)) via a fixed-point Taylor series (2**-30 scale).
  function automatic logic [10:0] sin_mag(input int unsigned i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = ((64'sd2 * longint'(i) + 64'sd1) * PI_S) >>> (Q_W + 2);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int unsigned k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return 11'((64'sd2047 * sum + (64'sd1 <<< 29)) >>> 30);
  endfunction

endpackage

// File: rtl/dds_sample_feeder_rom.sv
// Quarter-wave sine magnitude ROM, synchronous read, one port per channel.
module sine_quarter_rom
  import dds_pkg::*;
#(
  parameter int unsigned QADDR_W = Q_W,
  parameter int unsigned MAG_W   = 11
) (
  input  logic               clk,
  input  logic [QADDR_W-1:0] addr_a,
  input  logic [QADDR_W-1:0] addr_b,
  output logic [MAG_W-1:0]   q_a,
  output logic [MAG_W-1:0]   q_b
);

  logic [MAG_W-1:0] rom [2**QADDR_W];

  for (genvar i = 0; i < 2**QADDR_W; i++) begin : g_rom
    assign rom[i] = MAG_W'(sin_mag(i));
  end

  always_ff @(posedge clk) begin
    q_a <= rom[addr_a];
    q_b <= rom[addr_b];
  end

endmodule

// File: rtl/dds_sample_feeder.sv
// Two-channel DDS: sample-rate divider, phase accumulators, quarter-wave lookup
// and a go/ready issue FSM towards the dual-DAC serializer.
module dds_sample_feeder
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_W    = 32,
  parameter int unsigned QADDR_W    = Q_W,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned SAMPLE_DIV = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] freq_word1,
  input  logic [PHASE_W-1:0] freq_word2,
  input  logic [PHASE_W-1:0] phase_off2,
  input  logic               dac_ready,
  output logic               go,
  output logic [DATA_W-1:0]  data_out1,
  output logic [DATA_W-1:0]  data_out2,
  output logic               underrun
);

  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned MAG_W = DATA_W - 1;
  localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE);

  fsm_t               state, state_nx;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [PHASE_W-1:0] acc1, acc2, p2;
  qmap_t              map1_q, map2_q;
  logic [MAG_W-1:0]   mag1, mag2;
  logic [DATA_W-1:0]  pend1, pend2, out1_q, out2_q;

  assign tick = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign p2   = acc2 + phase_off2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      acc1    <= '0;
      acc2    <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      acc1    <= acc1 + freq_word1;
      acc2    <= acc2 + freq_word2;
    end else if (enable) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Lookup uses the pre-increment phase; overlapped ticks leave the map untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      map1_q <= '0;
      map2_q <= '0;
    end else if (tick && state == IDLE) begin
      map1_q <= quad_map(acc1[PHASE_W-1 -: Q_W+2]);
      map2_q <= quad_map(p2[PHASE_W-1 -: Q_W+2]);
    end
  end

  sine_quarter_rom #(
    .QADDR_W (QADDR_W),
    .MAG_W   (MAG_W)
  ) u_rom (
    .clk    (clk),
    .addr_a (map1_q.idx),
    .addr_b (map2_q.idx),
    .q_a    (mag1),
    .q_b    (mag2)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend1 <= MID;
      pend2 <= MID;
    end else if (state == CALC) begin
      pend1 <= map1_q.neg ? MID - {1'b0, mag1} : MID + {1'b0, mag1};
      pend2 <= map2_q.neg ? MID - {1'b0, mag2} : MID + {1'b0, mag2};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    unique case (state)
      IDLE:     if (tick) state_nx = FETCH;
      FETCH:    state_nx = CALC;
      CALC:     state_nx = WAIT_RDY;
      WAIT_RDY: begin
        if (dac_ready) begin
          go       = rst;
          state_nx = IDLE;
        end
      end
      default:  state_nx = IDLE;
    endcase
  end

  // Outputs present the pending pair during the go cycle itself, then hold it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out1_q <= MID;
      out2_q <= MID;
    end else if (go) begin
      out1_q <= pend1;
      out2_q <= pend2;
    end
  end

  assign data_out1 = go ? pend1 : out1_q;
  assign data_out2 = go ? pend2 : out2_q;

  always_ff @(posedge clk) begin
    if (!rst)                       underrun <= 1'b0;
    else if (tick && state != IDLE) underrun <= 1'b1;
  end

endmodule

// File: tb/tb_dds_sample_feeder.sv
// Randomized bench for dds_sample_feeder against a sample-period level model.
module tb_dds_sample_feeder;

  localparam int SD = 20;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst, enable, dac_ready;
  logic [31:0] freq_word1, freq_word2, phase_off2;
  logic        go, underrun;
  logic [11:0] data_out1, data_out2;

  int n_cmp = 0;
  int n_err = 0;
  int n_go  = 0;

  dds_sample_feeder #(
    .PHASE_W    (32),
    .QADDR_W    (8),
    .DATA_W     (12),
    .SAMPLE_DIV (SD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .freq_word1 (freq_word1),
    .freq_word2 (freq_word2),
    .phase_off2 (phase_off2),
    .dac_ready  (dac_ready),
    .go         (go),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Sine sampled at the centre of the 1/1024-turn bin the phase falls into.
  function automatic int ref_sample(input logic [31:0] ph);
    real s;
    int  mag;
    s   = 2047.0 * $sin((real'(ph >> 22) + 0.5) * 2.0 * PI / 1024.0);
    mag = $rtoi((s < 0.0 ? -s : s) + 0.5);
    return (s >= 0.0) ? 2048 + mag : 2048 - mag;
  endfunction

  // Reference state
  logic [31:0] macc1, macc2;
  longint      en_cnt, cyc, pend_t;
  bit          pend_v, m_under, exp_go, tk;
  int          pend_s1, pend_s2, last1, last2;

  task automatic model_reset();
    macc1 = '0; macc2 = '0; en_cnt = 0;
    pend_v = 0; m_under = 0;
    last1 = 2048; last2 = 2048;
  endtask

  initial model_reset();
  initial cyc = 0;

  always @(negedge clk) begin
    cyc++;
    exp_go = rst && pend_v && (cyc >= pend_t + 3) && dac_ready;
    check("go", int'(go), int'(exp_go));
    check("data_out1", int'(data_out1), exp_go ? pend_s1 : last1);
    check("data_out2", int'(data_out2), exp_go ? pend_s2 : last2);
    check("underrun", int'(underrun), int'(m_under));
    if (go) n_go++;
    if (!rst) begin
      model_reset();
    end else begin
      tk = enable && (en_cnt % SD == SD - 1);
      if (enable) en_cnt++;
      if (exp_go) begin
        last1 = pend_s1;
        last2 = pend_s2;
      end
      if (tk) begin
        if (pend_v) m_under = 1;
        else begin
          pend_v  = 1;
          pend_t  = cyc;
          pend_s1 = ref_sample(macc1);
          pend_s2 = ref_sample(macc2 + phase_off2);
        end
        macc1 = macc1 + freq_word1;
        macc2 = macc2 + freq_word2;
      end
      if (exp_go) pend_v = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int budget;
    rst = 1'b0; enable = 1'b0; dac_ready = 1'b1;
    freq_word1 = '0; freq_word2 = '0; phase_off2 = '0;

    // Reset held, then idle with enable low
    step(5);
    rst = 1'b1;
    step(60);

    // Quarter-turn steps on ch1, ch2 with static quarter offset
    freq_word1 = 32'h4000_0000;
    freq_word2 = '0;
    phase_off2 = 32'h4000_0000;
    enable = 1'b1;
    step(6 * SD);

    freq_word1 = '0;
    step(4 * SD);

    // Ready held low for a short stretch, then for longer than a sample period
    freq_word1 = 32'h0123_4567;
    freq_word2 = 32'h0765_4321;
    dac_ready = 1'b0; step(14);
    dac_ready = 1'b1; step(2 * SD);
    dac_ready = 1'b0; step(25);
    dac_ready = 1'b1; step(3 * SD);

    // Maximum frequency word wraps every period; then reset while waiting for ready
    rst = 1'b0; step(2); rst = 1'b1;
    freq_word1 = 32'hFFFF_FFFF;
    step(5 * SD);
    dac_ready = 1'b0;
    budget = 0;
    while (!(pend_v && cyc >= pend_t + 4) && budget < 4 * SD) begin
      step(1);
      budget++;
    end
    check("reach_wait_rdy", int'(budget < 4 * SD), 1);
    rst = 1'b0; step(2);
    rst = 1'b1; dac_ready = 1'b1;
    step(3 * SD);

    // Randomized traffic with occasional enable drops, ready gaps and resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) begin
        freq_word1 = $urandom;
        freq_word2 = $urandom;
        phase_off2 = $urandom;
      end
      enable    = ($urandom_range(0, 9) != 0);
      dac_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 499) != 0);
      step(1);
    end
    rst = 1'b1;
    step(4);

    check("go_seen", int'(n_go > 20), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
